// File: rtl/rb_cmd_rx.sv
// Byte-stream command receiver: parses framed write commands and drives the
// 4x16-bit register bank write port (bursts of 1-4 words, wrapping address).
module rb_cmd_rx #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk_reg,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [1:0]  addr,
    output logic [15:0] data_in,
    output logic        valid_reg,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  err_cnt
);

    localparam int unsigned CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam int unsigned IDLE_MAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
    localparam logic [3:0]  SYNC     = 4'hA;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HI   = 2'd1,
        S_LO   = 2'd2
    } state_t;

    state_t          state;
    logic [1:0]      rem;
    logic [1:0]      waddr;
    logic [7:0]      hi;
    logic [CW-1:0]   idle_cnt;
    logic            accept;
    logic            timeout_hit;
    logic [7:0]      err_inc;

    assign accept      = in_valid && in_ready;
    assign timeout_hit = (TIMEOUT != 0) && (idle_cnt == CW'(IDLE_MAX));
    assign err_inc     = (err_cnt == 8'hFF) ? err_cnt : err_cnt + 8'd1;

    // Frame parser; rem holds the number of words still to come after the current one.
    always_ff @(posedge clk_reg or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            addr       <= 2'd0;
            data_in    <= 16'd0;
            valid_reg  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err_cnt    <= 8'd0;
            rem        <= 2'd0;
            waddr      <= 2'd0;
            hi         <= 8'd0;
            idle_cnt   <= '0;
        end else begin
            in_ready   <= 1'b1;
            valid_reg  <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    idle_cnt <= '0;
                    if (accept) begin
                        if (in_data[7:4] == SYNC) begin
                            waddr <= in_data[1:0];
                            rem   <= in_data[3:2];
                            state <= S_HI;
                            busy  <= 1'b1;
                        end else begin
                            err_cnt <= err_inc;
                        end
                    end
                end
                S_HI, S_LO: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (state == S_HI) begin
                            hi    <= in_data;
                            state <= S_LO;
                        end else begin
                            valid_reg <= 1'b1;
                            addr      <= waddr;
                            data_in   <= {hi, in_data};
                            waddr     <= waddr + 2'd1;
                            if (rem == 2'd0) begin
                                frame_done <= 1'b1;
                                busy       <= 1'b0;
                                state      <= S_IDLE;
                            end else begin
                                rem   <= rem - 2'd1;
                                state <= S_HI;
                            end
                        end
                    end else if (timeout_hit) begin
                        // Stalled frame: drop any partial word, keep words already written.
                        idle_cnt <= '0;
                        busy     <= 1'b0;
                        state    <= S_IDLE;
                        err_cnt  <= err_inc;
                    end else if (TIMEOUT != 0) begin
                        idle_cnt <= idle_cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
